// File: rtl/ahb3lite_apb_req_arbiter.sv
// Round-robin arbiter that serialises NREQ simple request ports onto a single
// AHB-Lite master port (one NONSEQ SINGLE transfer at a time) with a data-phase watchdog.
module ahb3lite_apb_req_arbiter #(
  parameter int          NREQ       = 4,
  parameter int          HADDR_SIZE = 32,
  parameter int          HDATA_SIZE = 32,
  parameter int          TIMEOUT    = 256,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011,
  localparam int         IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_write,
  input  logic [3*NREQ-1:0]            req_size,
  input  logic [NREQ*HADDR_SIZE-1:0]   req_addr,
  input  logic [NREQ*HDATA_SIZE-1:0]   req_wdata,
  output logic                         resp_valid,
  output logic [IDW-1:0]               resp_id,
  output logic [HDATA_SIZE-1:0]        resp_rdata,
  output logic                         resp_err,
  output logic                         resp_timeout,
  output logic                         busy,
  output logic                         HSEL,
  output logic [HADDR_SIZE-1:0]        HADDR,
  output logic [HDATA_SIZE-1:0]        HWDATA,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [2:0]                   HBURST,
  output logic [3:0]                   HPROT,
  output logic [1:0]                   HTRANS,
  output logic                         HMASTLOCK,
  output logic                         HREADY,
  input  logic                         HREADYOUT,
  input  logic [HDATA_SIZE-1:0]        HRDATA,
  input  logic                         HRESP
);

  localparam int              TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DRAIN} state_t;

  state_t                  state, state_next;
  logic [IDW-1:0]          rr_last, cur, grant_idx;
  logic                    grant_found, handshake, timeout_hit;
  logic [TW-1:0]           to_cnt;
  logic [HADDR_SIZE-1:0]   lat_addr;
  logic [HDATA_SIZE-1:0]   lat_wdata;
  logic                    lat_write;
  logic [2:0]              lat_size;

  assign HADDR     = lat_addr;
  assign HWDATA    = lat_wdata;
  assign HWRITE    = lat_write;
  assign HSIZE     = lat_size;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HREADY    = HREADYOUT;
  assign busy      = (state != ST_IDLE);

  // Search upward from the requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!grant_found && req_valid[(int'(rr_last) + i) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(rr_last) + i) % NREQ);
      end
    end
  end

  assign handshake   = (state == ST_IDLE) && grant_found;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST) && !HREADYOUT;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    HSEL       = 1'b0;
    HTRANS     = 2'b00;
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = ST_ADDR;
        end
      end
      ST_ADDR: begin
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        if (HREADYOUT) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (HREADYOUT)        state_next = ST_IDLE;
        else if (timeout_hit) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (HREADYOUT) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // An error completes on its second cycle (HREADYOUT=1), so OKAY and ERROR share one path.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rr_last      <= LAST_ID;
      cur          <= '0;
      to_cnt       <= '0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_write    <= 1'b0;
      lat_size     <= 3'b000;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (handshake) begin
        lat_addr  <= req_addr[grant_idx*HADDR_SIZE +: HADDR_SIZE];
        lat_wdata <= req_wdata[grant_idx*HDATA_SIZE +: HDATA_SIZE];
        lat_write <= req_write[grant_idx];
        lat_size  <= req_size[grant_idx*3 +: 3];
        cur       <= grant_idx;
        rr_last   <= grant_idx;
      end
      if (state == ST_ADDR && HREADYOUT) to_cnt <= '0;
      if (state == ST_DATA) begin
        if (HREADYOUT) begin
          resp_valid   <= 1'b1;
          resp_id      <= cur;
          resp_err     <= HRESP;
          resp_timeout <= 1'b0;
          if (!HRESP) resp_rdata <= lat_write ? '0 : HRDATA;
        end else if (timeout_hit) begin
          resp_valid   <= 1'b1;
          resp_id      <= cur;
          resp_err     <= 1'b1;
          resp_timeout <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_apb_req_arbiter.sv
// Directed self-checking bench: one DUT with the default watchdog, a second with TIMEOUT=8.
module tb_ahb3lite_apb_req_arbiter;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [3:0]    req_valid, req_ready, req_write;
  logic [11:0]   req_size;
  logic [127:0]  req_addr, req_wdata;
  logic          resp_valid, resp_err, resp_timeout, busy;
  logic [1:0]    resp_id;
  logic [31:0]   resp_rdata;
  logic          HSEL, HWRITE, HMASTLOCK, HREADY, HREADYOUT, HRESP;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;

  logic [3:0]    t_valid, t_ready;
  logic          t_hready;
  logic          t_resp_valid, t_resp_err, t_resp_timeout, t_busy;
  logic [1:0]    t_resp_id;
  logic [31:0]   t_resp_rdata, t_haddr, t_hwdata;
  logic          t_hsel, t_hwrite, t_hmastlock, t_hready_fwd;
  logic [2:0]    t_hsize, t_hburst;
  logic [3:0]    t_hprot;
  logic [1:0]    t_htrans;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb3lite_apb_req_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  ahb3lite_apb_req_arbiter #(.TIMEOUT(8)) dut_to (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(t_valid), .req_ready(t_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(t_resp_valid), .resp_id(t_resp_id), .resp_rdata(t_resp_rdata),
    .resp_err(t_resp_err), .resp_timeout(t_resp_timeout), .busy(t_busy),
    .HSEL(t_hsel), .HADDR(t_haddr), .HWDATA(t_hwdata), .HWRITE(t_hwrite),
    .HSIZE(t_hsize), .HBURST(t_hburst), .HPROT(t_hprot), .HTRANS(t_htrans),
    .HMASTLOCK(t_hmastlock), .HREADY(t_hready_fwd), .HREADYOUT(t_hready),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step();
    step();
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_htrans: got %h expected 0", HTRANS); end
    n_tests++; if (HSEL !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_hsel: got %b expected 0", HSEL); end
    n_tests++; if (HADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_haddr: got %h expected 0", HADDR); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_req_ready: got %b expected 0000", req_ready); end
    n_tests++; if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_consts: got %h/%h/%b expected 0/3/0", HBURST, HPROT, HMASTLOCK);
    end
  endtask

  task automatic test_write_wait();
    req_valid = 4'b0001;
    req_write = 4'b0001;
    HREADYOUT = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL t1_ready: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    n_tests++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin n_fail++; $display("[TB] FAIL t1_nonseq: got %h/%b expected 2/1", HTRANS, HSEL); end
    n_tests++; if (HADDR !== 32'h4 || HWRITE !== 1'b1 || HSIZE !== 3'd0) begin
      n_fail++; $display("[TB] FAIL t1_addr: got %h/%b/%h expected 4/1/0", HADDR, HWRITE, HSIZE);
    end
    step();
    HREADYOUT = 1'b0;
    #1;
    n_tests++; if (HREADY !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_hready_copy: got %b expected 0", HREADY); end
    for (int i = 0; i < 10; i++) begin
      n_tests++; if (HWDATA !== 32'hA5 || HTRANS !== 2'b00 || resp_valid !== 1'b0) begin
        n_fail++; $display("[TB] FAIL t1_data_wait: got hwdata %h htrans %h resp_valid %b expected a5/0/0", HWDATA, HTRANS, resp_valid);
      end
      step();
    end
    HREADYOUT = 1'b1;
    step();
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL t1_resp: got valid %b id %0d err %b expected 1/0/0", resp_valid, resp_id, resp_err);
    end
    n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL t1_rdata: got %h expected 0", resp_rdata); end
    step();
    n_tests++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_after: got valid %b busy %b expected 0/0", resp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [31:0] rd_tab [6];
    logic [3:0]  exp_rdy;
    int g;
    rd_tab = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    do_reset();
    req_write = 4'b0000;
    req_valid = 4'b1111;
    HREADYOUT = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      exp_rdy = 4'b0001 << g;
      #1;
      n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("[TB] FAIL t2_grant%0d: got %b expected %b", k, req_ready, exp_rdy); end
      step();
      n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h1000 + 32'(g) * 32'h10) begin
        n_fail++; $display("[TB] FAIL t2_addr%0d: got %h/%h expected 2/%h", k, HTRANS, HADDR, 32'h1000 + 32'(g) * 32'h10);
      end
      step();
      HRDATA = rd_tab[k];
      step();
      n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'(g) || resp_rdata !== rd_tab[k]) begin
        n_fail++; $display("[TB] FAIL t2_resp%0d: got valid %b id %0d rdata %h expected 1/%0d/%h", k, resp_valid, resp_id, resp_rdata, g, rd_tab[k]);
      end
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_error();
    req_valid = 4'b0100;
    HREADYOUT = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL t3_ready: got %b expected 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    HRESP = 1'b1;
    HREADYOUT = 1'b0;
    step();
    n_tests++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL t3_err1: got valid %b busy %b expected 0/1", resp_valid, busy); end
    HREADYOUT = 1'b1;
    step();
    HRESP = 1'b0;
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_err !== 1'b1 || resp_timeout !== 1'b0) begin
      n_fail++; $display("[TB] FAIL t3_resp: got valid %b id %0d err %b to %b expected 1/2/1/0", resp_valid, resp_id, resp_err, resp_timeout);
    end
    req_valid = 4'b1011;
    #1;
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL t3_next_grant: got %b expected 1000", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    HRDATA = 32'h99;
    step();
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_err !== 1'b0 || resp_rdata !== 32'h99) begin
      n_fail++; $display("[TB] FAIL t3_req3: got valid %b id %0d err %b rdata %h expected 1/3/0/99", resp_valid, resp_id, resp_err, resp_rdata);
    end
    step();
  endtask

  task automatic test_timeout();
    t_hready = 1'b1;
    t_valid = 4'b0001;
    #1;
    n_tests++; if (t_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL t4_ready: got %b expected 0001", t_ready); end
    step();
    t_valid = 4'b0000;
    step();
    t_hready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_tests++; if (t_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_early%0d: got %b expected 0", i, t_resp_valid); end
      step();
    end
    n_tests++; if (t_busy !== 1'b1 || t_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_pre: got busy %b valid %b expected 1/0", t_busy, t_resp_valid); end
    step();
    n_tests++; if (t_resp_valid !== 1'b1 || t_resp_err !== 1'b1 || t_resp_timeout !== 1'b1 || t_busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL t4_resp: got valid %b err %b to %b busy %b expected 1/1/1/1", t_resp_valid, t_resp_err, t_resp_timeout, t_busy);
    end
    step();
    n_tests++; if (t_resp_valid !== 1'b0 || t_busy !== 1'b1 || t_htrans !== 2'b00) begin
      n_fail++; $display("[TB] FAIL t4_drain: got valid %b busy %b htrans %h expected 0/1/0", t_resp_valid, t_busy, t_htrans);
    end
    step();
    t_hready = 1'b1;
    step();
    n_tests++; if (t_busy !== 1'b0 || t_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_release: got busy %b valid %b expected 0/0", t_busy, t_resp_valid); end
    step();
    n_tests++; if (t_resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_no_second: got %b expected 0", t_resp_valid); end
  endtask

  task automatic test_addr_wait();
    req_valid = 4'b0010;
    HREADYOUT = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL t5_ready: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h1010 || HSIZE !== 3'd1) begin
        n_fail++; $display("[TB] FAIL t5_hold%0d: got %h/%h/%h expected 2/1010/1", i, HTRANS, HADDR, HSIZE);
      end
      step();
    end
    n_tests++; if (HTRANS !== 2'b10 || HADDR !== 32'h1010) begin n_fail++; $display("[TB] FAIL t5_hold3: got %h/%h expected 2/1010", HTRANS, HADDR); end
    HREADYOUT = 1'b1;
    step();
    n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL t5_data: got %h expected 0", HTRANS); end
    HRDATA = 32'h77;
    step();
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_rdata !== 32'h77) begin
      n_fail++; $display("[TB] FAIL t5_resp: got valid %b id %0d rdata %h expected 1/1/77", resp_valid, resp_id, resp_rdata);
    end
    step();
    n_tests++; if (resp_valid !== 1'b0 || HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL t5_single: got valid %b htrans %h expected 0/0", resp_valid, HTRANS); end
  endtask

  task automatic test_reset_in_data();
    req_valid = 4'b0100;
    HREADYOUT = 1'b1;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL t6_ready: got %b expected 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    step();
    HREADYOUT = 1'b0;
    step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL t6_in_data: got %b expected 1", busy); end
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    n_tests++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL t6_dropped: got htrans %h hsel %b busy %b valid %b expected 0/0/0/0", HTRANS, HSEL, busy, resp_valid);
    end
    HREADYOUT = 1'b1;
    req_valid = 4'b1011;
    #1;
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL t6_grant: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL t6_no_resp: got %b expected 0", resp_valid); end
    step();
    HRDATA = 32'h5A;
    step();
    n_tests++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_rdata !== 32'h5A) begin
      n_fail++; $display("[TB] FAIL t6_resp: got valid %b id %0d rdata %h expected 1/0/5a", resp_valid, resp_id, resp_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_size  = {3'd2, 3'd2, 3'd1, 3'd0};
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = 32'h1000 + 32'(i) * 32'h10;
      req_wdata[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
    end
    req_addr[31:0]  = 32'h0000_0004;
    req_wdata[31:0] = 32'h0000_00A5;
    HREADYOUT = 1'b1;
    HRDATA    = '0;
    HRESP     = 1'b0;
    t_valid   = '0;
    t_hready  = 1'b1;

    test_reset();
    test_write_wait();
    req_addr[31:0] = 32'h0000_1000;
    test_round_robin();
    test_error();
    test_timeout();
    test_addr_wait();
    test_reset_in_data();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
